// File: rtl/prio_encoder.sv
// Registered MSB-first priority encoder: index of the highest set request bit plus a valid flag.
// Optional PRIO_ENCO_ONEHOT_EN adds a registered one-hot grant vector (gnt).
module prio_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  output logic [OUT_W-1:0] Y,
`ifdef PRIO_ENCO_ONEHOT_EN
  output logic             valid,
  output logic [WIDTH-1:0] gnt
`else
  output logic             valid
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_y;
  logic             r_valid;

  // LSB-to-MSB scan; the last hit is the highest set bit. No hit leaves index 0.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (A[i]) w_idx = OUT_W'(i);
    end
  end

  assign w_any = |A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_idx;
      r_valid <= w_any;
    end
  end

  assign Y     = r_y;
  assign valid = r_valid;

`ifdef PRIO_ENCO_ONEHOT_EN
  logic [WIDTH-1:0] w_gnt;
  logic [WIDTH-1:0] r_gnt;

  always_comb begin
    w_gnt = '0;
    if (w_any) w_gnt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
    end else begin
      r_gnt <= w_gnt;
    end
  end

  assign gnt = r_gnt;
`endif

  a_req_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(A))
    else $error("prio_encoder: A contains X/Z while out of reset");

endmodule

// File: tb/tb_prio_encoder.sv
// Self-checking bench for prio_encoder (WIDTH = 8): vector table, reset corner cases, random run.
// Expected results go through a scoreboard queue in step with the one-cycle latency.
module tb_prio_encoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OUT_W = 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A;
  logic [OUT_W-1:0] Y;
  logic             valid;
`ifdef PRIO_ENCO_ONEHOT_EN
  logic [WIDTH-1:0] gnt;
`endif

  int n_checks;
  int n_errors;

  typedef struct {
    logic [OUT_W-1:0] y;
    logic             v;
    logic [WIDTH-1:0] g;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [OUT_W-1:0] y;
    logic             v;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  prio_encoder #(
    .WIDTH(WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .Y    (Y),
`ifdef PRIO_ENCO_ONEHOT_EN
    .valid(valid),
    .gnt  (gnt)
`else
    .valid(valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: search downward from the MSB, stop at the first set bit.
  function automatic exp_t model(input logic [WIDTH-1:0] a);
    exp_t e;
    bit   found;
    e.y   = '0;
    e.v   = 1'b0;
    e.g   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && a[i]) begin
        found = 1'b1;
        e.y   = OUT_W'(i);
        e.v   = 1'b1;
        e.g   = WIDTH'(1) << i;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, ".Y"}, 32'(Y), 32'(e.y));
    check({name, ".valid"}, 32'(valid), 32'(e.v));
`ifdef PRIO_ENCO_ONEHOT_EN
    check({name, ".gnt"}, 32'(gnt), 32'(e.g));
`endif
  endtask

  // Drive A at the falling edge, push its expectation, compare just after the next rising edge.
  task automatic drive(input string name, input logic [WIDTH-1:0] a, input exp_t e);
    exp_t got_e;
    @(negedge clk);
    A = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      check_outputs(name, got_e);
    end
  endtask

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.y = v.y;
    e.v = v.v;
    e.g = v.v ? (WIDTH'(1) << v.y) : '0;
    return e;
  endfunction

  function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [OUT_W-1:0] y,
                              input logic v);
    vec_t r;
    r.a = a;
    r.y = y;
    r.v = v;
    return r;
  endfunction

  exp_t e_tmp;

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs.push_back(mk(8'h00, 3'd0, 1'b0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(8'h01 << k, 3'(k), 1'b1));
    vecs.push_back(mk(8'hFF, 3'd7, 1'b1));
    vecs.push_back(mk(8'h7E, 3'd6, 1'b1));
    vecs.push_back(mk(8'h03, 3'd1, 1'b1));
    vecs.push_back(mk(8'h0A, 3'd3, 1'b1));
    vecs.push_back(mk(8'hFF, 3'd7, 1'b1));
    vecs.push_back(mk(8'h00, 3'd0, 1'b0));
    vecs.push_back(mk(8'h80, 3'd7, 1'b1));
    vecs.push_back(mk(8'h01, 3'd0, 1'b1));

    // Reset asserted with all requests high, before any clock edge.
    rst_n = 1'b0;
    A     = 8'hFF;
    #2;
    e_tmp = '{y: '0, v: 1'b0, g: '0};
    check_outputs("reset_no_edge", e_tmp);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("first_after_reset", model(8'hFF));

    foreach (vecs[i]) drive($sformatf("vec%0d", i), vecs[i].a, from_vec(vecs[i]));

    // Asynchronous reset mid-stream, well away from a clock edge.
    drive("pre_reset", 8'h40, from_vec(mk(8'h40, 3'd6, 1'b1)));
    #3;
    rst_n = 1'b0;
    #1;
    e_tmp = '{y: '0, v: 1'b0, g: '0};
    check_outputs("async_reset", e_tmp);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset", from_vec(mk(8'h40, 3'd6, 1'b1)));

    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra;
      ra = WIDTH'($urandom_range(0, 255));
      if (n % 16 == 0) ra = '0;
      drive("random", ra, model(ra));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
